// File: rtl/opb_arb_pkg.sv
// Shared encodings for the two-master OPB arbiter: FSM states, master IDs and
// the read-latency counter width.
package opb_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_ACK     = 2'd3;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int CNT_W = 3;

endpackage

// File: rtl/opb_rr_arb2.sv
// Combinational 2-way grant selector: round-robin on contention, or M0
// always wins contention when FIXED_PRIO is set.
module opb_rr_arb2
    import opb_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       gnt_id_o,
    output logic       gnt_valid_o
);

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_id_o    = M0;
        if (req_i == 2'b10) begin
            gnt_id_o = M1;
        end else if (req_i == 2'b11) begin
            // On a tie the master that did not win last time gets the bus.
            gnt_id_o = FIXED_PRIO ? M0 : ~last_grant_i;
        end
    end

endmodule

// File: rtl/opb_master_arbiter.sv
// Shares the OPB slave bus between M0 (APB bridge) and M1 (debug bridge):
// grant, one-cycle RE/WE strobe, fixed-latency read capture, one-cycle ACK.
module opb_master_arbiter
    import opb_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST_N,
    input  logic        M0_REQ,
    input  logic        M0_RNW,
    input  logic [31:0] M0_ADDR,
    input  logic [31:0] M0_WDATA,
    output logic        M0_ACK,
    output logic [31:0] M0_RDATA,
    input  logic        M1_REQ,
    input  logic        M1_RNW,
    input  logic [31:0] M1_ADDR,
    input  logic [31:0] M1_WDATA,
    output logic        M1_ACK,
    output logic [31:0] M1_RDATA,
    output logic        OPB_RE,
    output logic        OPB_WE,
    output logic [31:0] OPB_ADDR,
    output logic [31:0] OPB_DI,
    input  logic [31:0] OPB_DO,
    output logic        GNT_ID,
    output logic        BUSY
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rnw_q, rnw_d;
    logic             gnt_q, gnt_d;
    logic             last_q, last_d;
    logic             re_q, re_d, we_q, we_d;
    logic             ack0_q, ack0_d, ack1_q, ack1_d;
    logic             busy_q, busy_d;
    logic [31:0]      addr_q, addr_d, di_q, di_d;
    logic [31:0]      rd0_q, rd0_d, rd1_q, rd1_d;
    logic             win_id, win_vld;

    opb_rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .req_i       ({M1_REQ, M0_REQ}),
        .last_grant_i(last_q),
        .gnt_id_o    (win_id),
        .gnt_valid_o (win_vld)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rnw_d   = rnw_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        di_d    = di_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        re_d    = 1'b0;
        we_d    = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    gnt_d   = win_id;
                    last_d  = win_id;
                    rnw_d   = (win_id == M1) ? M1_RNW   : M0_RNW;
                    addr_d  = (win_id == M1) ? M1_ADDR  : M0_ADDR;
                    di_d    = (win_id == M1) ? M1_WDATA : M0_WDATA;
                    // Strobes are registered, so they are launched with the grant.
                    re_d    = rnw_d;
                    we_d    = ~rnw_d;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (rnw_q) begin
                    cnt_d   = CNT_W'(RD_LATENCY);
                    state_d = ST_RD_WAIT;
                end else begin
                    ack0_d  = (gnt_q == M0);
                    ack1_d  = (gnt_q == M1);
                    state_d = ST_ACK;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    if (gnt_q == M1) rd1_d = OPB_DO;
                    else             rd0_d = OPB_DO;
                    ack0_d  = (gnt_q == M0);
                    ack1_d  = (gnt_q == M1);
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rnw_q   <= 1'b0;
            gnt_q   <= M0;
            last_q  <= M1;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            di_q    <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnw_q   <= rnw_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            re_q    <= re_d;
            we_q    <= we_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            di_q    <= di_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    assign OPB_RE   = re_q;
    assign OPB_WE   = we_q;
    assign OPB_ADDR = addr_q;
    assign OPB_DI   = di_q;
    assign M0_ACK   = ack0_q;
    assign M1_ACK   = ack1_q;
    assign M0_RDATA = rd0_q;
    assign M1_RDATA = rd1_q;
    assign GNT_ID   = gnt_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_opb_master_arbiter.sv
// Bench for opb_master_arbiter: three instances (RR/lat1, fixed/lat1, RR/lat3)
// with a delayed OPB_DO model and a queue of expected completions.
module tb_opb_master_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        m0_req [3], m0_rnw [3], m1_req [3], m1_rnw [3];
    logic [31:0] m0_addr [3], m0_wdata [3], m1_addr [3], m1_wdata [3], rd_val [3];
    logic        m0_ack [3], m1_ack [3], opb_re [3], opb_we [3], gnt_id [3], busy [3];
    logic [31:0] m0_rdata [3], m1_rdata [3], opb_addr [3], opb_di [3], opb_do [3];

    typedef struct {
        int          m;
        int          due;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;
    exp_t sbq[$];

    int n_cmp = 0;
    int n_bad = 0;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int LAT  = (g == 2) ? 3 : 1;
            localparam bit PRIO = (g == 1);
            // Decoder model: valid data exactly LAT cycles after RE, junk otherwise.
            logic [3:0] pipe = '0;
            always @(posedge clk) pipe <= {pipe[2:0], opb_re[g]};
            assign opb_do[g] = pipe[LAT-1] ? rd_val[g] : (32'hBAD0_0000 | 32'(cyc & 16'hFFFF));

            opb_master_arbiter #(
                .RD_LATENCY(LAT),
                .FIXED_PRIO(PRIO)
            ) u_dut (
                .OPB_CLK  (clk),
                .OPB_RST_N(rst_n),
                .M0_REQ   (m0_req[g]),
                .M0_RNW   (m0_rnw[g]),
                .M0_ADDR  (m0_addr[g]),
                .M0_WDATA (m0_wdata[g]),
                .M0_ACK   (m0_ack[g]),
                .M0_RDATA (m0_rdata[g]),
                .M1_REQ   (m1_req[g]),
                .M1_RNW   (m1_rnw[g]),
                .M1_ADDR  (m1_addr[g]),
                .M1_WDATA (m1_wdata[g]),
                .M1_ACK   (m1_ack[g]),
                .M1_RDATA (m1_rdata[g]),
                .OPB_RE   (opb_re[g]),
                .OPB_WE   (opb_we[g]),
                .OPB_ADDR (opb_addr[g]),
                .OPB_DI   (opb_di[g]),
                .OPB_DO   (opb_do[g]),
                .GNT_ID   (gnt_id[g]),
                .BUSY     (busy[g])
            );
        end
    endgenerate

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] txn_addr(int m, int i);
        return 32'h100 * (m + 1) + 32'(4 * i);
    endfunction

    function automatic logic [31:0] txn_data(int m, int i);
        return 32'hC0DE_0000 | 32'(m << 8) | 32'(i);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        for (int g = 0; g < 3; g++) begin
            n_cmp++;
            if ({opb_re[g], opb_we[g], m0_ack[g], m1_ack[g], gnt_id[g], busy[g]} !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_ctrl[%0d]: got %b want 000000", g,
                         {opb_re[g], opb_we[g], m0_ack[g], m1_ack[g], gnt_id[g], busy[g]});
            end
            n_cmp++;
            if ((opb_addr[g] | opb_di[g] | m0_rdata[g] | m1_rdata[g]) !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_data[%0d]: addr %h di %h rd0 %h rd1 %h want 0", g,
                         opb_addr[g], opb_di[g], m0_rdata[g], m1_rdata[g]);
            end
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (busy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_busy: got %b want 0", busy[0]);
        end
    endtask

    task automatic test_single_write();
        exp_t e;
        m0_rnw[0]   = 1'b0;
        m0_addr[0]  = 32'h0000_0010;
        m0_wdata[0] = 32'hDEAD_BEEF;
        m0_req[0]   = 1'b1;
        sbq.push_back('{0, cyc + 2, 32'h10, 32'hDEAD_BEEF, 32'h0});
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++;
            if (opb_we[0] !== (k == 1) || opb_re[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL wr_strobe k=%0d: we %b re %b want we %b re 0", k, opb_we[0], opb_re[0], k == 1);
            end
            if (k == 1) begin
                n_cmp++;
                if (opb_addr[0] !== 32'h10 || opb_di[0] !== 32'hDEAD_BEEF) begin
                    n_bad++;
                    $display("FAIL wr_bus: addr %h di %h want 00000010 deadbeef", opb_addr[0], opb_di[0]);
                end
            end
            n_cmp++;
            if (m0_ack[0] !== (k == 2) || m1_ack[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL wr_ack k=%0d: m0 %b m1 %b want m0 %b m1 0", k, m0_ack[0], m1_ack[0], k == 2);
            end
            if (m0_ack[0] === 1'b1 && sbq.size() > 0) begin
                e = sbq.pop_front();
                m0_req[0] = 1'b0;
                n_cmp++;
                if (cyc !== e.due) begin
                    n_bad++;
                    $display("FAIL wr_ack_cycle: got %0d want %0d", cyc, e.due);
                end
            end
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL wr_pending: got %0d outstanding want 0", sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_single_read();
        exp_t e;
        rd_val[0]  = 32'h1234_5678;
        m1_rnw[0]  = 1'b1;
        m1_addr[0] = 32'h0000_0200;
        m1_req[0]  = 1'b1;
        sbq.push_back('{1, cyc + 3, 32'h200, 32'h0, 32'h1234_5678});
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_cmp++;
            if (opb_re[0] !== (k == 1) || opb_we[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL rd_strobe k=%0d: re %b we %b want re %b we 0", k, opb_re[0], opb_we[0], k == 1);
            end
            if (k == 1) begin
                n_cmp++;
                if (opb_addr[0] !== 32'h200 || gnt_id[0] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rd_grant: addr %h gnt %b want 00000200 1", opb_addr[0], gnt_id[0]);
                end
            end
            n_cmp++;
            if (m0_ack[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL rd_m0_ack k=%0d: got %b want 0", k, m0_ack[0]);
            end
            if (m1_ack[0] === 1'b1) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL rd_extra_ack: got ack want none at cycle %0d", cyc);
                end else begin
                    e = sbq.pop_front();
                    m1_req[0] = 1'b0;
                    if (cyc !== e.due || m1_rdata[0] !== e.rdata || gnt_id[0] !== 1'b1) begin
                        n_bad++;
                        $display("FAIL rd_ack: cycle %0d rdata %h gnt %b want %0d %h 1",
                                 cyc, m1_rdata[0], gnt_id[0], e.due, e.rdata);
                    end
                end
            end
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL rd_pending: got %0d outstanding want 0", sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_back_to_back(input int g);
        exp_t e;
        int   cnt [2];
        int   got;
        int   m;
        int   c0;
        bit   fixed;
        fixed = (g == 1);
        c0    = cyc;
        cnt   = '{0, 0};
        for (int j = 0; j < 8; j++) begin
            m = fixed ? ((j < 4) ? 0 : 1) : (j % 2);
            got = fixed ? (j % 4) : (j / 2);
            sbq.push_back('{m, c0 + 2 + 3 * j, txn_addr(m, got), txn_data(m, got), 32'h0});
        end
        m0_rnw[g] = 1'b0; m0_addr[g] = txn_addr(0, 0); m0_wdata[g] = txn_data(0, 0);
        m1_rnw[g] = 1'b0; m1_addr[g] = txn_addr(1, 0); m1_wdata[g] = txn_data(1, 0);
        m0_req[g] = 1'b1;
        m1_req[g] = 1'b1;
        for (int t = 0; t < 60 && sbq.size() > 0; t++) begin
            tick();
            n_cmp++;
            if (opb_re[g] !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b%0d_re: got %b want 0", g, opb_re[g]);
            end
            if (opb_we[g] === 1'b1) begin
                n_cmp++;
                if (opb_addr[g] !== sbq[0].addr || opb_di[g] !== sbq[0].wdata) begin
                    n_bad++;
                    $display("FAIL b2b%0d_bus: addr %h di %h want %h %h", g,
                             opb_addr[g], opb_di[g], sbq[0].addr, sbq[0].wdata);
                end
            end
            if (m0_ack[g] === 1'b1 || m1_ack[g] === 1'b1) begin
                e   = sbq.pop_front();
                got = (m1_ack[g] === 1'b1) ? 1 : 0;
                n_cmp++;
                if (got !== e.m || (m0_ack[g] & m1_ack[g]) !== 1'b0 || gnt_id[g] !== 1'(e.m)) begin
                    n_bad++;
                    $display("FAIL b2b%0d_order: acks %b%b gnt %b want master %0d", g,
                             m1_ack[g], m0_ack[g], gnt_id[g], e.m);
                end
                n_cmp++;
                if (cyc !== e.due) begin
                    n_bad++;
                    $display("FAIL b2b%0d_ack_cycle: got %0d want %0d", g, cyc, e.due);
                end
                cnt[got]++;
                if (got == 0) begin
                    if (cnt[0] < 4) begin
                        m0_addr[g] = txn_addr(0, cnt[0]); m0_wdata[g] = txn_data(0, cnt[0]);
                    end else m0_req[g] = 1'b0;
                end else begin
                    if (cnt[1] < 4) begin
                        m1_addr[g] = txn_addr(1, cnt[1]); m1_wdata[g] = txn_data(1, cnt[1]);
                    end else m1_req[g] = 1'b0;
                end
            end
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL b2b%0d_timeout: got %0d outstanding want 0", g, sbq.size());
        end
        sbq.delete();
        m0_req[g] = 1'b0;
        m1_req[g] = 1'b0;
        tick();
    endtask

    task automatic test_rd_latency();
        exp_t e;
        rd_val[2]  = 32'hA5A5_0001;
        m0_rnw[2]  = 1'b1;
        m0_addr[2] = 32'h0000_0300;
        m0_req[2]  = 1'b1;
        sbq.push_back('{0, cyc + 5, 32'h300, 32'h0, 32'hA5A5_0001});
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_cmp++;
            if (opb_re[2] !== (k == 1)) begin
                n_bad++;
                $display("FAIL lat3_re k=%0d: got %b want %b", k, opb_re[2], k == 1);
            end
            if (k < 5) begin
                n_cmp++;
                if (m0_rdata[2] !== 32'h0 || m0_ack[2] !== 1'b0 || busy[2] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL lat3_early k=%0d: rdata %h ack %b busy %b want 0 0 1",
                             k, m0_rdata[2], m0_ack[2], busy[2]);
                end
            end
            if (m0_ack[2] === 1'b1) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL lat3_extra_ack: got ack want none at cycle %0d", cyc);
                end else begin
                    e = sbq.pop_front();
                    m0_req[2] = 1'b0;
                    if (cyc !== e.due || m0_rdata[2] !== e.rdata) begin
                        n_bad++;
                        $display("FAIL lat3_ack: cycle %0d rdata %h want %0d %h", cyc, m0_rdata[2], e.due, e.rdata);
                    end
                end
            end
        end
        n_cmp++;
        if (sbq.size() != 0 || m0_rdata[2] !== 32'hA5A5_0001) begin
            n_bad++;
            $display("FAIL lat3_final: outstanding %0d rdata %h want 0 a5a50001", sbq.size(), m0_rdata[2]);
        end
        sbq.delete();
    endtask

    task automatic test_reset_mid();
        m1_rnw[2]  = 1'b1;
        m1_addr[2] = 32'h0000_0204;
        m1_req[2]  = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (busy[2] !== 1'b1 || opb_re[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_pre: busy %b re %b want 1 0", busy[2], opb_re[2]);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({opb_re[2], opb_we[2], m0_ack[2], m1_ack[2], busy[2]} !== 5'b0) begin
            n_bad++;
            $display("FAIL rst_mid_async: got %b want 00000",
                     {opb_re[2], opb_we[2], m0_ack[2], m1_ack[2], busy[2]});
        end
        m1_req[2] = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_cmp++;
            if (m1_ack[2] !== 1'b0 || busy[2] !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_mid_dropped k=%0d: ack %b busy %b want 0 0", k, m1_ack[2], busy[2]);
            end
        end
        m0_rnw[2] = 1'b0; m0_addr[2] = 32'h44; m0_wdata[2] = 32'h1111_0000;
        m1_rnw[2] = 1'b0; m1_addr[2] = 32'h88; m1_wdata[2] = 32'h2222_0000;
        m0_req[2] = 1'b1;
        m1_req[2] = 1'b1;
        tick();
        n_cmp++;
        if (gnt_id[2] !== 1'b0 || opb_we[2] !== 1'b1 || opb_addr[2] !== 32'h44) begin
            n_bad++;
            $display("FAIL rst_tie_grant: gnt %b we %b addr %h want 0 1 00000044", gnt_id[2], opb_we[2], opb_addr[2]);
        end
        tick();
        n_cmp++;
        if (m0_ack[2] !== 1'b1 || m1_ack[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_tie_ack: m0 %b m1 %b want 1 0", m0_ack[2], m1_ack[2]);
        end
        m0_req[2] = 1'b0;
        m1_req[2] = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < 3; g++) begin
            m0_req[g] = 1'b0; m0_rnw[g] = 1'b0; m0_addr[g] = '0; m0_wdata[g] = '0;
            m1_req[g] = 1'b0; m1_rnw[g] = 1'b0; m1_addr[g] = '0; m1_wdata[g] = '0;
            rd_val[g] = '0;
        end
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back(0);
        test_back_to_back(1);
        test_rd_latency();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
